vram_arb: RTL

Time-slot arbiter sharing the single display SDRAM port between the VGA pixel fetch stream and CPU byte writes to VRAM, all in the `clk25` dot-clock domain. Each clock is one slot. During the active window, slots alternate between display read and CPU write. During blanking, every slot is a write slot. CPU writes are buffered in a small FIFO so the CPU is never stalled by display traffic. An optional clear engine fills VRAM with a constant after reset.

---
 rtl/vram_pkg.sv | 29 ++
 rtl/vram_wfifo.sv | 70 +++++++
 rtl/vram_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the VRAM slot arbiter.
// Holds the arbiter state enum, bus widths, byte strobes and FIFO entry layout.
package vram_pkg;

    localparam int VRAM_ADDR_W = 24;
    localparam int VRAM_DATA_W = 16;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } vram_state_e;

    // Entries are stored pre-formatted: word address, strobes, byte.
    typedef struct packed {
        logic [VRAM_ADDR_W-2:0] waddr;
        logic [1:0]             ds;
        logic [7:0]             data;
    } vram_wr_t;

    function automatic logic [1:0] byte_ds(input logic a0);
        return a0 ? DS_HI : DS_LO;
    endfunction

endpackage

// File: rtl/vram_wfifo.sv
// vram_wfifo: synchronous CPU write FIFO with registered full/empty flags.
// A push is refused while the registered full flag is set.
module vram_wfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nxt;
    logic          r_full;
    logic          r_empty;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push & ~r_full;
    assign w_pop   = i_pop & ~r_empty;
    assign o_dout  = r_mem[r_rp];
    assign o_full  = r_full;
    assign o_empty = r_empty;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_cnt_nxt = r_cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/vram_arb.sv
// vram_arb: time-slot arbiter sharing the display SDRAM port between pixel reads
// and buffered CPU byte writes. Define VRAM_ARB_CLEAR_EN for the post-reset clear engine.
module vram_arb
    import vram_pkg::*;
#(
    parameter int                     FIFO_DEPTH  = 4,
    parameter logic [VRAM_ADDR_W-1:0] CLEAR_WORDS = 24'h04B000,
    parameter logic [VRAM_DATA_W-1:0] CLEAR_DATA  = 16'h0000
) (
    input  logic                   clk25,
    input  logic                   reset_n,
    input  logic                   active,
    input  logic                   vsync_n,
    input  logic                   wr_req,
    input  logic [VRAM_ADDR_W-1:0] wr_addr,
    input  logic [7:0]             wr_data,
    output logic                   wr_full,
    output logic                   wr_ack,
    input  logic                   clr_req,
    output logic                   busy,
    output logic [VRAM_ADDR_W-1:0] sd_addr,
    output logic [VRAM_DATA_W-1:0] sd_din,
    output logic [1:0]             sd_ds,
    output logic                   sd_we,
    output logic                   sd_oe
);

    vram_state_e            r_state;
    logic                   r_ph;
    logic [VRAM_ADDR_W-1:0] r_rptr;
    logic [VRAM_ADDR_W-1:0] r_addr;
    logic [VRAM_DATA_W-1:0] r_din;
    logic [1:0]             r_ds;
    logic                   r_we;
    logic                   r_oe;
    logic                   r_ack;

    logic                   w_rd_slot;
    logic                   w_pop;
    logic                   w_acc;
    logic                   w_full;
    logic                   w_empty;
    logic [VRAM_ADDR_W-1:0] w_rptr;
    vram_wr_t               w_in;
    vram_wr_t               w_ent;

`ifdef VRAM_ARB_CLEAR_EN
    logic [VRAM_ADDR_W-1:0] r_clr_cnt;
    logic                   r_busy;
    assign busy = r_busy;
`else
    logic w_unused;
    assign w_unused = ^{clr_req, CLEAR_WORDS, CLEAR_DATA};
    assign busy     = 1'b0;
`endif

    assign w_rd_slot = active & ~r_ph;
    assign w_pop     = ~w_rd_slot & (r_state == RUN) & ~w_empty;
    assign w_acc     = wr_req & ~w_full;
    assign w_rptr    = vsync_n ? r_rptr : '0;
    assign w_in      = '{waddr: wr_addr[VRAM_ADDR_W-1:1],
                         ds:    byte_ds(wr_addr[0]),
                         data:  wr_data};

    assign wr_full = w_full;
    assign wr_ack  = r_ack;
    assign sd_addr = r_addr;
    assign sd_din  = r_din;
    assign sd_ds   = r_ds;
    assign sd_we   = r_we;
    assign sd_oe   = r_oe;

    vram_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(vram_wr_t))
    ) u_wfifo (
        .i_clk   (clk25),
        .i_rst_n (reset_n),
        .i_push  (wr_req),
        .i_din   (w_in),
        .i_pop   (w_pop),
        .o_dout  (w_ent),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
            r_ph    <= 1'b0;
            r_rptr  <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_ds    <= 2'b00;
            r_we    <= 1'b0;
            r_oe    <= 1'b0;
            r_ack   <= 1'b0;
`ifdef VRAM_ARB_CLEAR_EN
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
`endif
        end else begin
            r_ack <= w_acc;
            r_ph  <= active & ~r_ph;
            r_oe  <= w_rd_slot;
            r_we  <= w_pop;
            if (!vsync_n) begin
                r_rptr <= '0;
            end else if (w_rd_slot) begin
                r_rptr <= r_rptr + 24'd1;
            end
            // Write slots with nothing to send keep the last address.
            if (w_rd_slot) begin
                r_addr <= w_rptr;
            end else if (w_pop) begin
                r_addr <= {1'b0, w_ent.waddr};
                r_din  <= {2{w_ent.data}};
                r_ds   <= w_ent.ds;
            end
            unique case (r_state)
                INIT: begin
`ifdef VRAM_ARB_CLEAR_EN
                    r_state   <= CLEAR;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
`else
                    r_state <= RUN;
`endif
                end
                CLEAR: begin
`ifdef VRAM_ARB_CLEAR_EN
                    if (!w_rd_slot) begin
                        r_we      <= 1'b1;
                        r_addr    <= r_clr_cnt;
                        r_din     <= CLEAR_DATA;
                        r_ds      <= DS_BOTH;
                        r_clr_cnt <= r_clr_cnt + 24'd1;
                        if (r_clr_cnt == CLEAR_WORDS - 24'd1) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                        end
                    end
`else
                    r_state <= RUN;
`endif
                end
                RUN: begin
`ifdef VRAM_ARB_CLEAR_EN
                    if (clr_req) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
`endif
                end
                default: r_state <= INIT;
            endcase
        end
    end

endmodule
